// File: rtl/i2c_serial_interface.sv
// Byte-level I2C slave engine: address/register/data decode, ACK generation,
// register-file write strobes and read serialisation behind a START/STOP front-end.
module i2c_serial_interface (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [1:0] start_stop_det_state,
  output logic       clear_start_stop_det,
  input  logic [7:0] slave_addr,
  output logic [7:0] reg_addr,
  output logic [7:0] data_out,
  output logic       write_en,
  input  logic [7:0] data_in
);

  typedef enum logic [2:0] {
    IDLE, RX_BIT, RX_DONE, ACK_HOLD, TX_BIT, TX_ACK, TX_NEXT
  } state_t;

  typedef enum logic [1:0] {
    DEV_ADDR, REG_ADDR, WRITE_DATA, READ
  } stream_t;

  state_t      state, state_n;
  stream_t     stream, stream_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        rw, rw_n;
  logic        scl_s1, scl_s2;
  logic        sda_out_n, clear_n, write_en_n;
  logic [7:0]  reg_addr_n, data_out_n;
  logic        rise, fall, addr_match;

  assign rise = scl_s1 & ~scl_s2;
  assign fall = ~scl_s1 & scl_s2;
  // Bit 0 of slave_addr is the R/W slot of the write-form address, so it is masked out.
  assign addr_match = ((rx_shift ^ slave_addr) & 8'hFE) == 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      stream               <= DEV_ADDR;
      bit_cnt              <= 4'd0;
      rx_shift             <= 8'h00;
      tx_shift             <= 8'h00;
      rw                   <= 1'b0;
      scl_s1               <= 1'b1;
      scl_s2               <= 1'b1;
      sda_out              <= 1'b1;
      clear_start_stop_det <= 1'b0;
      write_en             <= 1'b0;
      reg_addr             <= 8'h00;
      data_out             <= 8'h00;
    end else begin
      state                <= state_n;
      stream               <= stream_n;
      bit_cnt              <= bit_cnt_n;
      rx_shift             <= rx_shift_n;
      tx_shift             <= tx_shift_n;
      rw                   <= rw_n;
      scl_s1               <= scl;
      scl_s2               <= scl_s1;
      sda_out              <= sda_out_n;
      clear_start_stop_det <= clear_n;
      write_en             <= write_en_n;
      reg_addr             <= reg_addr_n;
      data_out             <= data_out_n;
    end
  end

  always_comb begin
    state_n    = state;
    stream_n   = stream;
    bit_cnt_n  = bit_cnt;
    rx_shift_n = rx_shift;
    tx_shift_n = tx_shift;
    rw_n       = rw;
    sda_out_n  = sda_out;
    clear_n    = 1'b0;
    write_en_n = 1'b0;
    reg_addr_n = reg_addr;
    data_out_n = data_out;

    // The pointer advances the cycle after the strobe so the user sees the written address.
    if (write_en)
      reg_addr_n = reg_addr + 8'd1;

    // The detector state is still pending while our clear pulse is out, so skip that cycle.
    if (!clear_start_stop_det && start_stop_det_state == 2'b01) begin
      clear_n   = 1'b1;
      stream_n  = DEV_ADDR;
      bit_cnt_n = 4'd0;
      sda_out_n = 1'b1;
      state_n   = RX_BIT;
    end else if (!clear_start_stop_det && start_stop_det_state == 2'b10) begin
      clear_n   = 1'b1;
      sda_out_n = 1'b1;
      state_n   = IDLE;
    end else begin
      case (state)
        IDLE: sda_out_n = 1'b1;
        RX_BIT: begin
          if (rise) begin
            rx_shift_n = {rx_shift[6:0], sda_in};
            bit_cnt_n  = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7)
              state_n = RX_DONE;
          end
        end
        RX_DONE: begin
          if (fall) begin
            case (stream)
              DEV_ADDR: begin
                if (addr_match) begin
                  sda_out_n = 1'b0;
                  rw_n      = rx_shift[0];
                  state_n   = ACK_HOLD;
                end else begin
                  sda_out_n = 1'b1;
                  state_n   = IDLE;
                end
              end
              REG_ADDR: begin
                reg_addr_n = rx_shift;
                sda_out_n  = 1'b0;
                stream_n   = WRITE_DATA;
                state_n    = ACK_HOLD;
              end
              default: begin
                data_out_n = rx_shift;
                write_en_n = 1'b1;
                sda_out_n  = 1'b0;
                state_n    = ACK_HOLD;
              end
            endcase
          end
        end
        ACK_HOLD: begin
          if (fall) begin
            sda_out_n = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = RX_BIT;
            if (stream == DEV_ADDR) begin
              if (rw) begin
                stream_n   = READ;
                tx_shift_n = {data_in[6:0], 1'b0};
                sda_out_n  = data_in[7];
                bit_cnt_n  = 4'd1;
                state_n    = TX_BIT;
              end else begin
                stream_n = REG_ADDR;
              end
            end
          end
        end
        TX_BIT: begin
          if (fall) begin
            if (bit_cnt == 4'd8) begin
              sda_out_n = 1'b1;
              state_n   = TX_ACK;
            end else begin
              sda_out_n  = tx_shift[7];
              tx_shift_n = {tx_shift[6:0], 1'b0};
              bit_cnt_n  = bit_cnt + 4'd1;
            end
          end
        end
        TX_ACK: begin
          if (rise) begin
            if (!sda_in) begin
              reg_addr_n = reg_addr + 8'd1;
              state_n    = TX_NEXT;
            end else begin
              sda_out_n = 1'b1;
              state_n   = IDLE;
            end
          end
        end
        TX_NEXT: begin
          // data_in already reflects the advanced pointer by the time SCL falls.
          if (fall) begin
            tx_shift_n = {data_in[6:0], 1'b0};
            sda_out_n  = data_in[7];
            bit_cnt_n  = 4'd1;
            state_n    = TX_BIT;
          end
        end
        default: begin
          sda_out_n = 1'b1;
          state_n   = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_serial_interface.sv
// Self-checking bench: bit-banged I2C master, START/STOP front-end stand-in and
// a transaction-level model of the register pointer, writes and read data.
module tb_i2c_serial_interface;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, scl, sda_m, start_req, stop_req;
  logic [1:0] det;
  logic [7:0] slave_addr;
  logic       sda_out, clear_start_stop_det, write_en;
  logic [7:0] reg_addr, data_out, data_in;
  logic       sda_bus;

  assign sda_bus = sda_m & sda_out;
  assign data_in = reg_addr + 8'h80;

  i2c_serial_interface dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .scl                  (scl),
    .sda_in               (sda_bus),
    .sda_out              (sda_out),
    .start_stop_det_state (det),
    .clear_start_stop_det (clear_start_stop_det),
    .slave_addr           (slave_addr),
    .reg_addr             (reg_addr),
    .data_out             (data_out),
    .write_en             (write_en),
    .data_in              (data_in)
  );

  // Front-end stand-in: holds the detected condition until the engine clears it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    det <= 2'b00;
    else if (clear_start_stop_det) det <= 2'b00;
    else if (start_req)            det <= 2'b01;
    else if (stop_req)             det <= 2'b10;
  end

  int checks = 0, errors = 0;
  logic [15:0] wr_log[$];
  int low_cnt = 0, clr_cnt = 0, we_long = 0;
  logic we_prev = 1'b0;
  int model_ptr;

  always @(negedge clk) begin
    if (write_en) begin
      wr_log.push_back({reg_addr, data_out});
      if (we_prev) we_long <= we_long + 1;
    end
    if (sda_out == 1'b0) low_cnt <= low_cnt + 1;
    if (clear_start_stop_det) clr_cnt <= clr_cnt + 1;
    we_prev <= write_en;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      sda_m = 1'b1; clks(2); scl = 1'b1; clks(2);
    end
    sda_m = 1'b0; start_req = 1'b1; clks(1); start_req = 1'b0; clks(3);
    scl = 1'b0; clks(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(2); scl = 1'b1; clks(2);
    sda_m = 1'b1; stop_req = 1'b1; clks(1); stop_req = 1'b0; clks(4);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      clks(2); sda_m = b[i]; clks(2); scl = 1'b1; clks(4); scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    clks(2); sda_m = 1'b1; clks(2); scl = 1'b1; clks(2);
    ack = sda_bus;
    clks(2); scl = 1'b0;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clks(4); scl = 1'b1; clks(2); b = {b[6:0], sda_bus}; clks(2); scl = 1'b0;
    end
    clks(2); sda_m = ack; clks(2); scl = 1'b1; clks(4); scl = 1'b0; clks(2);
    sda_m = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; start_req = 1'b0; stop_req = 1'b0;
    slave_addr = 8'hA0;
    clks(3);
    checks++; if (sda_out !== 1'b1) begin errors++; $display("[TB] FAIL reset sda_out: got %b expected 1", sda_out); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("[TB] FAIL reset write_en: got %b expected 0", write_en); end
    checks++; if (clear_start_stop_det !== 1'b0) begin errors++; $display("[TB] FAIL reset clear: got %b expected 0", clear_start_stop_det); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset reg_addr: got %h expected 00", reg_addr); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset data_out: got %h expected 00", data_out); end
    rst_n = 1'b1; clks(2);
    model_ptr = 0;
  endtask

  task automatic test_write();
    int base, clr0, long0;
    logic a0, a1, a2;
    base = wr_log.size(); clr0 = clr_cnt; long0 = we_long;
    i2c_start(); send_byte(8'hA0, a0); send_byte(8'h10, a1); send_byte(8'h5A, a2); i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("[TB] FAIL write acks: got %b expected 000", {a0, a1, a2}); end
    checks++; if (wr_log.size() - base !== 1) begin errors++; $display("[TB] FAIL write count: got %0d expected 1", wr_log.size() - base); end
    else begin
      checks++; if (wr_log[base] !== 16'h105A) begin errors++; $display("[TB] FAIL write entry: got %h expected 105a", wr_log[base]); end
    end
    checks++; if (we_long !== long0) begin errors++; $display("[TB] FAIL write_en width: got %0d long pulses expected 0", we_long - long0); end
    checks++; if (reg_addr !== 8'h11) begin errors++; $display("[TB] FAIL write ptr: got %h expected 11", reg_addr); end
    checks++; if (clr_cnt - clr0 !== 2) begin errors++; $display("[TB] FAIL clear pulses: got %0d expected 2", clr_cnt - clr0); end
    model_ptr = 8'h11;
  endtask

  task automatic test_mismatch();
    int base, low0;
    logic a0, a1;
    base = wr_log.size(); low0 = low_cnt;
    i2c_start(); send_byte(8'hA2, a0); send_byte(8'h10, a1); i2c_stop();
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("[TB] FAIL mismatch acks: got %b expected 11", {a0, a1}); end
    checks++; if (low_cnt !== low0) begin errors++; $display("[TB] FAIL mismatch sda low cycles: got %0d expected 0", low_cnt - low0); end
    checks++; if (wr_log.size() !== base) begin errors++; $display("[TB] FAIL mismatch writes: got %0d expected 0", wr_log.size() - base); end
    checks++; if (reg_addr !== 8'(model_ptr)) begin errors++; $display("[TB] FAIL mismatch ptr: got %h expected %h", reg_addr, 8'(model_ptr)); end
  endtask

  task automatic test_burst_wrap();
    int base;
    logic a, acks;
    logic [7:0] d;
    logic [15:0] exp_e;
    base = wr_log.size(); acks = 1'b0;
    i2c_start(); send_byte(8'hA0, a); acks |= a; send_byte(8'hFE, a); acks |= a;
    for (int k = 1; k <= 3; k++) begin d = 8'(k); send_byte(d, a); acks |= a; end
    i2c_stop();
    checks++; if (acks !== 1'b0) begin errors++; $display("[TB] FAIL burst acks: got nack expected all ack"); end
    checks++; if (wr_log.size() - base !== 3) begin errors++; $display("[TB] FAIL burst count: got %0d expected 3", wr_log.size() - base); end
    else for (int k = 0; k < 3; k++) begin
      exp_e = {8'((254 + k) % 256), 8'(k + 1)};
      checks++; if (wr_log[base + k] !== exp_e) begin errors++; $display("[TB] FAIL burst entry %0d: got %h expected %h", k, wr_log[base + k], exp_e); end
    end
    checks++; if (reg_addr !== 8'h01) begin errors++; $display("[TB] FAIL burst ptr: got %h expected 01", reg_addr); end
    model_ptr = 1;
  endtask

  task automatic test_read();
    int base, low0;
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    base = wr_log.size();
    i2c_start(); send_byte(8'hA0, a0); send_byte(8'h20, a1);
    i2c_start(); send_byte(8'hA1, a2);
    read_byte(1'b0, b0);
    checks++; if (reg_addr !== 8'h21) begin errors++; $display("[TB] FAIL read ptr after ack: got %h expected 21", reg_addr); end
    read_byte(1'b1, b1);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("[TB] FAIL read acks: got %b expected 000", {a0, a1, a2}); end
    checks++; if (b0 !== 8'hA0) begin errors++; $display("[TB] FAIL read byte0: got %h expected a0", b0); end
    checks++; if (b1 !== 8'hA1) begin errors++; $display("[TB] FAIL read byte1: got %h expected a1", b1); end
    checks++; if (reg_addr !== 8'h21) begin errors++; $display("[TB] FAIL read ptr after nack: got %h expected 21", reg_addr); end
    low0 = low_cnt;
    send_bits(8'h00, 8);
    checks++; if (low_cnt !== low0 || sda_out !== 1'b1) begin errors++; $display("[TB] FAIL read idle after nack: got %0d low cycles expected 0", low_cnt - low0); end
    checks++; if (wr_log.size() !== base) begin errors++; $display("[TB] FAIL read writes: got %0d expected 0", wr_log.size() - base); end
    i2c_stop();
    model_ptr = 8'h21;
  endtask

  task automatic test_stop_mid_byte();
    int base;
    logic a0, a1, a2, a3;
    base = wr_log.size();
    i2c_start(); send_byte(8'hA0, a0); send_byte(8'h30, a1); send_bits(8'hFF, 4); i2c_stop();
    checks++; if (wr_log.size() !== base) begin errors++; $display("[TB] FAIL partial writes: got %0d expected 0", wr_log.size() - base); end
    checks++; if (reg_addr !== 8'h30) begin errors++; $display("[TB] FAIL partial ptr: got %h expected 30", reg_addr); end
    i2c_start(); send_byte(8'hA0, a2); send_byte(8'h40, a3); send_byte(8'h77, a1); i2c_stop();
    checks++; if ({a0, a2, a3, a1} !== 4'b0000) begin errors++; $display("[TB] FAIL partial acks: got %b expected 0000", {a0, a2, a3, a1}); end
    checks++; if (wr_log.size() - base !== 1 || wr_log[wr_log.size() - 1] !== 16'h4077) begin errors++; $display("[TB] FAIL partial recovery write: got %0d entries expected one 4077", wr_log.size() - base); end
    model_ptr = 8'h41;
  endtask

  task automatic test_random();
    int base, low0, kind, n;
    logic a, acks;
    logic [7:0] r, d, dev, b, exp_b;
    logic [15:0] exp_q[$];
    slave_addr = 8'hA1;
    for (int t = 0; t < 10; t++) begin
      kind = $urandom_range(0, 2);
      r = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      base = wr_log.size(); low0 = low_cnt; acks = 1'b0;
      exp_q.delete();
      if (kind == 0) begin
        i2c_start(); send_byte(8'hA0, a); acks |= a; send_byte(r, a); acks |= a;
        model_ptr = r;
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom_range(0, 255));
          send_byte(d, a); acks |= a;
          exp_q.push_back({8'(model_ptr), d});
          model_ptr = (model_ptr + 1) % 256;
        end
        i2c_stop();
        checks++; if (acks !== 1'b0) begin errors++; $display("[TB] FAIL rand %0d write acks: got nack expected ack", t); end
        checks++; if (wr_log.size() - base !== n) begin errors++; $display("[TB] FAIL rand %0d write count: got %0d expected %0d", t, wr_log.size() - base, n); end
        else for (int k = 0; k < n; k++) begin
          checks++; if (wr_log[base + k] !== exp_q[k]) begin errors++; $display("[TB] FAIL rand %0d write %0d: got %h expected %h", t, k, wr_log[base + k], exp_q[k]); end
        end
      end else if (kind == 1) begin
        i2c_start(); send_byte(8'hA0, a); acks |= a; send_byte(r, a); acks |= a;
        i2c_start(); send_byte(8'hA1, a); acks |= a;
        model_ptr = r;
        for (int k = 0; k < n; k++) begin
          read_byte(k == n - 1, b);
          exp_b = 8'((model_ptr + 128) % 256);
          checks++; if (b !== exp_b) begin errors++; $display("[TB] FAIL rand %0d read %0d: got %h expected %h", t, k, b, exp_b); end
          if (k < n - 1) model_ptr = (model_ptr + 1) % 256;
        end
        i2c_stop();
        checks++; if (acks !== 1'b0 || wr_log.size() !== base) begin errors++; $display("[TB] FAIL rand %0d read setup: got acks %b writes %0d expected 0 0", t, acks, wr_log.size() - base); end
      end else begin
        dev = 8'($urandom_range(0, 255));
        if (dev[7:1] == 7'h50) dev[7:1] = 7'h51;
        i2c_start(); send_byte(dev, a); acks = a; send_byte(r, a); acks &= a; i2c_stop();
        checks++; if (acks !== 1'b1 || low_cnt !== low0 || wr_log.size() !== base) begin errors++; $display("[TB] FAIL rand %0d mismatch dev %h: got low %0d writes %0d expected 0 0", t, dev, low_cnt - low0, wr_log.size() - base); end
      end
      checks++; if (reg_addr !== 8'(model_ptr)) begin errors++; $display("[TB] FAIL rand %0d ptr: got %h expected %h", t, reg_addr, 8'(model_ptr)); end
    end
    slave_addr = 8'hA0;
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2;
    int base;
    i2c_start(); send_byte(8'hA0, a0); send_byte(8'h80, a1);
    i2c_start(); send_byte(8'hA1, a2);
    clks(4);
    checks++; if (sda_out !== 1'b0) begin errors++; $display("[TB] FAIL midread drive: got %b expected 0", sda_out); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (sda_out !== 1'b1) begin errors++; $display("[TB] FAIL async reset sda_out: got %b expected 1", sda_out); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("[TB] FAIL async reset reg_addr: got %h expected 00", reg_addr); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("[TB] FAIL async reset write_en: got %b expected 0", write_en); end
    scl = 1'b1; sda_m = 1'b1; clks(3); rst_n = 1'b1; clks(2);
    base = wr_log.size();
    i2c_start(); send_byte(8'hA0, a0); send_byte(8'h05, a1); send_byte(8'h66, a2); i2c_stop();
    checks++; if (wr_log.size() - base !== 1 || wr_log[wr_log.size() - 1] !== 16'h0566 || reg_addr !== 8'h06) begin errors++; $display("[TB] FAIL post-reset write: got %0d entries ptr %h expected one 0566 ptr 06", wr_log.size() - base, reg_addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_burst_wrap();
    test_read();
    test_stop_mid_byte();
    test_random();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
